// File: rtl/cluster_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cluster_acc_pkg
// Description : Shared types and default constants for the cluster sum
//               accumulator (FSM state encoding, default geometry).
// Revision    : 1.0  initial release
// ============================================================================
package cluster_acc_pkg;

    localparam int c_default_num_clusters = 4;
    localparam int c_default_data_w       = 64;
    localparam int c_default_cnt_w        = 32;

    // ACCUM: samples are summed into clusters; DRAIN: clusters are emitted
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/acc_adder64.sv
`default_nettype none
// ============================================================================
// Module      : acc_adder64
// Description : WIDTH-bit adder with carry-in and carry-out, shared by all
//               cluster accumulators.
// Revision    : 1.0  initial release
// ============================================================================
module acc_adder64 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit on the operands captures the carry-out
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/cluster_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : cluster_sum_accumulator
// Description : Per-cluster sum and sample-count accumulators. Samples are
//               accumulated while in ACCUM; a flush switches to DRAIN, which
//               emits every cluster in ascending order over a valid/ready
//               handshake and clears all accumulators on the final one.
//               Optional macro CLUSTER_ACC_OVF_EN enables the sticky
//               overflow flag (sum carry-out or count wrap).
// Revision    : 1.0  initial release
// ============================================================================
module cluster_sum_accumulator
    import cluster_acc_pkg::*;
#(
    parameter int NUM_CLUSTERS = c_default_num_clusters,
    parameter int DATA_W       = c_default_data_w,
    parameter int CNT_W        = c_default_cnt_w
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    input  logic [$clog2(NUM_CLUSTERS)-1:0] in_cluster,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(NUM_CLUSTERS)-1:0] out_cluster,
    output logic [DATA_W-1:0]               out_sum,
    output logic [CNT_W-1:0]                out_count,
    output logic                            out_last,
    output logic                            ovf
);

    localparam int                 c_idx_w    = $clog2(NUM_CLUSTERS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_CLUSTERS - 1);

    acc_state_t          r_state;
    logic [c_idx_w-1:0]  r_idx;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_sum   [NUM_CLUSTERS];
    logic [CNT_W-1:0]    r_count [NUM_CLUSTERS];

    logic                w_accept;
    logic                w_out_fire;
    logic                w_drain_done;
    logic [DATA_W-1:0]   w_sum_cur;
    logic [DATA_W-1:0]   w_sum_nxt;
    logic [CNT_W-1:0]    w_cnt_cur;
    logic [CNT_W-1:0]    w_cnt_nxt;

    assign w_accept     = in_valid && r_in_ready;
    assign w_out_fire   = r_out_valid && out_ready;
    assign w_drain_done = w_out_fire && (r_idx == c_last_idx);

    // Only the addressed cluster feeds the single shared adder
    assign w_sum_cur = r_sum[in_cluster];
    assign w_cnt_cur = r_count[in_cluster];
    assign w_cnt_nxt = w_cnt_cur + CNT_W'(1);

`ifdef CLUSTER_ACC_OVF_EN
    logic w_cout;
    logic r_ovf;

    acc_adder64 #(
        .WIDTH (DATA_W)
    ) u_adder (
        .a    (w_sum_cur),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (w_sum_nxt),
        .cout (w_cout)
    );

    // Sticky overflow: set on sum carry-out or count wrap, cleared by reset or drain end
    always_ff @(posedge clk) begin
        if (rst || w_drain_done) begin
            r_ovf <= 1'b0;
        end else if (w_accept && (w_cout || (&w_cnt_cur))) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    // Carry-out is not observed when overflow detection is compiled out
    logic w_unused_cout;

    acc_adder64 #(
        .WIDTH (DATA_W)
    ) u_adder (
        .a    (w_sum_cur),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (w_sum_nxt),
        .cout (w_unused_cout)
    );

    assign ovf = 1'b0;
`endif

    // Cluster storage: accumulate accepted samples, clear on reset or drain end
    always_ff @(posedge clk) begin
        if (rst || w_drain_done) begin
            for (int i = 0; i < NUM_CLUSTERS; i++) begin
                r_sum[i]   <= '0;
                r_count[i] <= '0;
            end
        end else if (w_accept) begin
            r_sum[in_cluster]   <= w_sum_nxt;
            r_count[in_cluster] <= w_cnt_nxt;
        end
    end

    // Control FSM: ACCUM until flush, then walk every cluster in DRAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (flush) begin
                        r_state     <= DRAIN;
                        r_idx       <= '0;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (r_idx == c_last_idx) begin
                            r_state     <= ACCUM;
                            r_idx       <= '0;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_idx <= r_idx + c_idx_w'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_idx       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Result path is driven from the drain index and held while stalled
    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_cluster = r_idx;
    assign out_sum     = r_out_valid ? r_sum[r_idx]   : '0;
    assign out_count   = r_out_valid ? r_count[r_idx] : '0;
    assign out_last    = r_out_valid && (r_idx == c_last_idx);

endmodule
`default_nettype wire

// File: tb/tb_cluster_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_cluster_sum_accumulator
// Description : Scoreboard bench for cluster_sum_accumulator. Expected drain
//               results are queued at flush time from a reference model and
//               compared as the DUT emits them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cluster_sum_accumulator;

`ifdef CLUSTER_ACC_OVF_EN
    localparam bit c_ovf_en = 1'b1;
`else
    localparam bit c_ovf_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_cluster;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_cluster;
    logic [63:0] out_sum;
    logic [31:0] out_count;
    logic        out_last;
    logic        ovf;

    typedef struct {
        logic [1:0]  cl;
        logic [63:0] sum;
        logic [31:0] cnt;
        logic        last;
    } exp_t;

    exp_t        r_sb[$];
    logic [63:0] m_sum [4];
    logic [31:0] m_cnt [4];
    logic        m_ovf;
    int          n_tests = 0;
    int          n_fail  = 0;

    cluster_sum_accumulator u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_cluster  (in_cluster),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_cluster (out_cluster),
        .out_sum     (out_sum),
        .out_count   (out_count),
        .out_last    (out_last),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_sum[i] = '0;
            m_cnt[i] = '0;
        end
    endtask

    task automatic push_drain();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.cl   = 2'(i);
            e.sum  = m_sum[i];
            e.cnt  = m_cnt[i];
            e.last = (i == 3);
            r_sb.push_back(e);
        end
        model_clear();
    endtask

    // One accepted sample (optionally with flush in the same cycle)
    task automatic sample(input logic [63:0] d, input logic [1:0] c, input logic f);
        logic [64:0] t;
        check("in_ready_accum", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_data    = d;
        in_cluster = c;
        flush      = f;
        t = {1'b0, m_sum[c]} + {1'b0, d};
        if (c_ovf_en && (t[64] || (&m_cnt[c]))) m_ovf = 1'b1;
        m_sum[c] = t[63:0];
        m_cnt[c] = m_cnt[c] + 32'd1;
        if (f) push_drain();
        cycle();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("ovf_after_sample", 64'(ovf), 64'(m_ovf));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        push_drain();
        cycle();
        flush = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty, then check the return to ACCUM
    task automatic wait_drain();
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (r_sb.size() == 0) break;
        end
        check("drain_done", 64'(r_sb.size()), 64'd0);
        m_ovf = 1'b0;
        check("in_ready_after_drain", 64'(in_ready), 64'd1);
        check("out_valid_after_drain", 64'(out_valid), 64'd0);
        check("ovf_after_drain", 64'(ovf), 64'd0);
    endtask

    // Scoreboard monitor: compare each completed output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (r_sb.size() == 0) begin
                check("unexpected_result", 64'(out_cluster), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = r_sb.pop_front();
                check("out_cluster", 64'(out_cluster), 64'(e.cl));
                check("out_sum",     out_sum,          e.sum);
                check("out_count",   64'(out_count),   64'(e.cnt));
                check("out_last",    64'(out_last),    64'(e.last));
            end
        end
    end

    initial begin
        logic [63:0] held_sum;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_cluster = '0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        m_ovf      = 1'b0;
        model_clear();

        // Reset state
        cycle();
        cycle();
        check("rst_in_ready",    64'(in_ready),    64'd1);
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_sum",     out_sum,          64'd0);
        check("rst_out_count",   64'(out_count),   64'd0);
        check("rst_out_cluster", 64'(out_cluster), 64'd0);
        check("rst_out_last",    64'(out_last),    64'd0);
        check("rst_ovf",         64'(ovf),         64'd0);
        rst = 1'b0;
        cycle();

        // Basic accumulate and drain
        sample(64'd1,   2'd0, 1'b0);
        sample(64'd16,  2'd0, 1'b0);
        sample(64'd500, 2'd2, 1'b0);
        sample(64'd3,   2'd2, 1'b0);
        check("model_c0_sum", r_sb.size() == 0 ? m_sum[0] : 64'd0, 64'd17);
        check("model_c2_sum", m_sum[2], 64'd503);
        do_flush();
        wait_drain();

        // Sample in the same cycle as flush is included
        sample(64'd7, 2'd0, 1'b0);
        sample(64'd5, 2'd1, 1'b1);
        wait_drain();

        // Stalled drain: outputs hold, no samples accepted, flush ignored
        out_ready = 1'b0;
        sample(64'd9, 2'd0, 1'b0);
        do_flush();
        held_sum = out_sum;
        for (int k = 0; k < 3; k++) begin
            in_valid   = 1'b1;
            in_data    = 64'd99;
            in_cluster = 2'(k);
            flush      = 1'b1;
            check("stall_out_valid",   64'(out_valid),   64'd1);
            check("stall_out_cluster", 64'(out_cluster), 64'(r_sb[0].cl));
            check("stall_out_sum",     out_sum,          r_sb[0].sum);
            check("stall_sum_stable",  out_sum,          held_sum);
            check("stall_in_ready",    64'(in_ready),    64'd0);
            cycle();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Sum wrap-around and overflow flag
        sample(64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1'b0);
        sample(64'd2,                   2'd3, 1'b0);
        check("ovf_expected", 64'(ovf), 64'(c_ovf_en));
        do_flush();
        wait_drain();

        // Reset while emitting cluster 1
        sample(64'd4, 2'd1, 1'b0);
        do_flush();
        cycle();
        check("mid_drain_cluster", 64'(out_cluster), 64'd1);
        rst = 1'b1;
        r_sb.delete();
        model_clear();
        m_ovf = 1'b0;
        cycle();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        check("mid_rst_out_sum",   out_sum,        64'd0);
        rst = 1'b0;
        cycle();
        do_flush();
        wait_drain();

        // Back-to-back samples into one cluster
        for (int k = 0; k < 8; k++) sample(64'd10, 2'd3, 1'b0);
        check("model_c3_sum", m_sum[3], 64'd80);
        do_flush();
        wait_drain();

        check("sb_empty_end", 64'(r_sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cluster_sum_accumulator.md
CLUSTER_SUM_ACCUMULATOR -- requirements
Module: cluster_sum_accumulator

Interface
REQ-001 The module SHALL have parameter NUM_CLUSTERS, default 4: number of independent cluster accumulators, power of two, 2..16.
REQ-002 The module SHALL have parameter DATA_W, default 64: sample and sum width.
REQ-003 The module SHALL have parameter CNT_W, default 32: per-cluster sample-count width.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active high.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  unsigned sample value.
- in_cluster  in  log2(NUM_CLUSTERS)  target cluster index.
- flush  in  1  single-cycle request to emit and clear all accumulators.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_cluster  out  log2(NUM_CLUSTERS)  cluster index of the result.
- out_sum  out  DATA_W  accumulated sum.
- out_count  out  CNT_W  accepted-sample count.
- out_last  out  1  result is the final cluster of the drain.
- ovf  out  1  sticky overflow flag (see Configuration).

Function
REQ-005 The FSM SHALL have exactly two states: ACCUM and DRAIN.
REQ-006 In ACCUM, in_ready SHALL be 1; a sample SHALL be accepted when in_valid && in_ready are both 1 at a rising edge.
REQ-007 An accepted sample SHALL update sum[in_cluster] <= sum[in_cluster] + in_data and count[in_cluster] <= count[in_cluster] + 1 at that same edge (latency 1).
REQ-008 Sum arithmetic SHALL be modulo 2^DATA_W; count arithmetic SHALL be modulo 2^CNT_W (wrap-around, no saturation).
REQ-009 flush=1 in ACCUM SHALL move the FSM to DRAIN at the next edge; a sample accepted in the same cycle as flush SHALL be included in the drained results.
REQ-010 In DRAIN, in_ready SHALL be 0, and flush SHALL be ignored.
REQ-011 In DRAIN, out_valid SHALL be 1 and SHALL present clusters in ascending order 0..NUM_CLUSTERS-1, one per out_valid && out_ready handshake.
REQ-012 While out_valid=1 && out_ready=0, out_cluster, out_sum, out_count and out_last SHALL hold stable.
REQ-013 out_last SHALL be 1 only when out_cluster = NUM_CLUSTERS-1.
REQ-014 The handshake on the last cluster SHALL clear all sums and counts to 0 and return the FSM to ACCUM at the same edge, so in_ready=1 in the next cycle.
REQ-015 Clusters that received no samples SHALL still be emitted, with sum=0 and count=0.
REQ-016 In ACCUM, out_valid SHALL be 0; out_sum, out_count and out_cluster are don't-care when out_valid=0.

Reset
REQ-017 rst=1 at an edge SHALL force ACCUM and clear all sums, counts, the drain index and ovf to 0, including a reset asserted mid-drain.
REQ-018 During and after reset: in_ready=1 and out_valid=0 after the first reset edge; all other outputs SHALL be 0.

Configuration
REQ-019 Macro CLUSTER_ACC_OVF_EN SHALL control overflow detection.
- Defined: ovf SHALL set at the edge where any sum addition produces carry-out=1 or any count wraps, and SHALL clear only on rst or on the final drain handshake.
- Undefined: ovf SHALL be tied to 0 and no carry-detection logic SHALL be present.

Structure
REQ-020 The shared package cluster_acc_pkg SHALL hold the FSM state enum (ACCUM, DRAIN) and the default constants for NUM_CLUSTERS, DATA_W and CNT_W.
REQ-021 A single sub-module, acc_adder64, SHALL implement the DATA_W-bit sum-plus-carry-in adder (ports a, b, cin, sum, cout); it SHALL be instantiated once and shared by all clusters, with cin=0.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset, then samples (data 1, cluster 0), (16, cluster 0), (500, cluster 2), (3, cluster 2), then flush, out_ready=1 -> results in order: c0 sum 17 cnt 2; c1 0/0; c2 503/2; c3 0/0 with out_last=1; in_ready=1 the following cycle.
- Sample (5, cluster 1) presented in the same cycle as flush -> drain reports c1 sum 5 cnt 1.
- out_ready held 0 for 3 cycles during drain -> out_cluster 0 and its sum stable for 3 cycles; in_ready=0 throughout; in_valid samples not accepted.
- Samples (2^64-1, c3) and (2, c3), then flush -> c3 sum 1 cnt 2; ovf=1 with the macro defined, ovf=0 without; ovf=0 after the drain completes.
- rst asserted while emitting cluster 1 -> next cycle out_valid=0, in_ready=1; a second flush with no samples yields four results, all 0/0.
- Back-to-back in_valid for 8 cycles on cluster 3 with data 10 -> c3 sum 80 cnt 8.
